// File: rtl/fifo_param.sv
// Parameterised word/byte FIFO: word pushes with lane enables, byte-wise slot
// assembly through a byte pointer, registered 1-cycle-latency reads, sticky errors.
module fifo_param #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned LANES = 4,
    localparam int unsigned W     = 8 * LANES,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned BW    = $clog2(LANES)
) (
    input  logic             CLK,
    input  logic             RST_FIFO_,
    input  logic             FLUSH,
    input  logic [W-1:0]     DIN,
    input  logic             WR_WORD,
    input  logic [LANES-1:0] WR_BE,
    input  logic             WR_BYTE,
    input  logic             BPTR_LD,
    input  logic [BW-1:0]    BPTR_VAL,
    input  logic             RD,
    input  logic             ERR_CLR,
    output logic [W-1:0]     DOUT,
    output logic             DOUT_VALID,
    output logic             FULL,
    output logic             EMPTY,
    output logic [AW:0]      COUNT,
    output logic [BW-1:0]    BPTR,
    output logic             BPTR_EQ0,
    output logic             BPTR_LAST,
    output logic             PARTIAL,
    output logic             OVF,
    output logic             UDF
);

    localparam int unsigned LAST = LANES - 1;

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;

    logic             push_req;
    logic             pop_ok;
    logic             push_ok;
    logic             byte_wr;
    logic             commit;
    logic             bptr_load;
    logic [LANES-1:0] lane_en;
    logic [AW:0]      count_nxt;
    logic [BW-1:0]    bptr_nxt;
    logic             partial_nxt;
    logic             ovf_nxt;
    logic             udf_nxt;

    // Acceptance, commit and next-state decode; a full FIFO still takes a push
    // when a pop frees a slot in the same cycle.
    always_comb begin
        push_req    = WR_WORD | WR_BYTE;
        pop_ok      = RD & ~EMPTY;
        push_ok     = push_req & (~FULL | pop_ok);
        byte_wr     = push_ok & ~WR_WORD;
        commit      = push_ok & (WR_WORD | BPTR_LAST);
        bptr_load   = BPTR_LD & ~push_req & ~PARTIAL;
        lane_en     = WR_WORD ? WR_BE : (LANES'(1) << BPTR);
        count_nxt   = COUNT + (AW+1)'(commit) - (AW+1)'(pop_ok);
        bptr_nxt    = BPTR;
        partial_nxt = PARTIAL;
        if (commit) begin
            bptr_nxt    = '0;
            partial_nxt = 1'b0;
        end else if (byte_wr) begin
            bptr_nxt    = BPTR + BW'(1);
            partial_nxt = 1'b1;
        end else if (bptr_load) begin
            bptr_nxt    = BPTR_VAL;
        end
        ovf_nxt = (push_req & ~push_ok) | (OVF & ~ERR_CLR);
        udf_nxt = (RD & EMPTY) | (UDF & ~ERR_CLR);
    end

    // Storage: lane-masked writes into slot WP; FLUSH leaves contents alone.
    always_ff @(posedge CLK or negedge RST_FIFO_) begin
        if (!RST_FIFO_) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!FLUSH && push_ok) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (lane_en[l]) begin
                    mem[wp][l*8 +: 8] <= DIN[l*8 +: 8];
                end
            end
        end
    end

    // Pointers, occupancy, read port and status flags.
    always_ff @(posedge CLK or negedge RST_FIFO_) begin
        if (!RST_FIFO_) begin
            wp         <= '0;
            rp         <= '0;
            COUNT      <= '0;
            FULL       <= 1'b0;
            EMPTY      <= 1'b1;
            BPTR       <= '0;
            BPTR_EQ0   <= 1'b1;
            BPTR_LAST  <= 1'b0;
            PARTIAL    <= 1'b0;
            OVF        <= 1'b0;
            UDF        <= 1'b0;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
        end else if (FLUSH) begin
            wp         <= '0;
            rp         <= '0;
            COUNT      <= '0;
            FULL       <= 1'b0;
            EMPTY      <= 1'b1;
            BPTR       <= '0;
            BPTR_EQ0   <= 1'b1;
            BPTR_LAST  <= 1'b0;
            PARTIAL    <= 1'b0;
            OVF        <= 1'b0;
            UDF        <= 1'b0;
            DOUT_VALID <= 1'b0;
        end else begin
            if (commit) begin
                wp <= wp + AW'(1);
            end
            if (pop_ok) begin
                rp   <= rp + AW'(1);
                DOUT <= mem[rp];
            end
            DOUT_VALID <= pop_ok;
            COUNT      <= count_nxt;
            FULL       <= (count_nxt == (AW+1)'(DEPTH));
            EMPTY      <= (count_nxt == '0);
            BPTR       <= bptr_nxt;
            BPTR_EQ0   <= (bptr_nxt == '0);
            BPTR_LAST  <= (bptr_nxt == BW'(LAST));
            PARTIAL    <= partial_nxt;
            OVF        <= ovf_nxt;
            UDF        <= udf_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed vectors with literal expectations plus a
// slot-array/occupancy model compared against every output on each falling edge.
module tb_fifo_param;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned LANES = 4;
    localparam int unsigned W     = 32;

    logic          CLK;
    logic          RST_FIFO_;
    logic          FLUSH;
    logic [W-1:0]  DIN;
    logic          WR_WORD;
    logic [3:0]    WR_BE;
    logic          WR_BYTE;
    logic          BPTR_LD;
    logic [1:0]    BPTR_VAL;
    logic          RD;
    logic          ERR_CLR;
    logic [W-1:0]  DOUT;
    logic          DOUT_VALID;
    logic          FULL;
    logic          EMPTY;
    logic [3:0]    COUNT;
    logic [1:0]    BPTR;
    logic          BPTR_EQ0;
    logic          BPTR_LAST;
    logic          PARTIAL;
    logic          OVF;
    logic          UDF;

    fifo_param #(.DEPTH(DEPTH), .LANES(LANES)) dut (
        .CLK(CLK), .RST_FIFO_(RST_FIFO_), .FLUSH(FLUSH), .DIN(DIN),
        .WR_WORD(WR_WORD), .WR_BE(WR_BE), .WR_BYTE(WR_BYTE),
        .BPTR_LD(BPTR_LD), .BPTR_VAL(BPTR_VAL), .RD(RD), .ERR_CLR(ERR_CLR),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .FULL(FULL), .EMPTY(EMPTY),
        .COUNT(COUNT), .BPTR(BPTR), .BPTR_EQ0(BPTR_EQ0), .BPTR_LAST(BPTR_LAST),
        .PARTIAL(PARTIAL), .OVF(OVF), .UDF(UDF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: physical slots plus running push/pop totals; occupancy is their difference.
    logic [W-1:0] m_mem [DEPTH];
    int           n_push, n_pop, m_bptr;
    logic         m_partial, m_ovf, m_udf, m_dv, model_live;
    logic [W-1:0] m_dout;

    initial model_live = 1'b0;

    always @(posedge CLK or negedge RST_FIFO_) begin : model
        int   cnt, slot;
        logic want_push, pop_ok, push_ok, set_ovf, set_udf;
        if (!RST_FIFO_) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            n_push = 0; n_pop = 0; m_bptr = 0;
            m_partial = 0; m_ovf = 0; m_udf = 0; m_dv = 0; m_dout = '0;
            model_live = 1'b1;
        end else if (FLUSH) begin
            n_push = 0; n_pop = 0; m_bptr = 0;
            m_partial = 0; m_ovf = 0; m_udf = 0; m_dv = 0;
        end else begin
            cnt       = n_push - n_pop;
            slot      = n_push % DEPTH;
            want_push = WR_WORD || WR_BYTE;
            pop_ok    = RD && (cnt > 0);
            push_ok   = want_push && ((cnt < DEPTH) || pop_ok);
            set_ovf   = want_push && !push_ok;
            set_udf   = RD && (cnt == 0);
            m_dv      = pop_ok;
            if (pop_ok) begin
                m_dout = m_mem[n_pop % DEPTH];
                n_pop++;
            end
            if (push_ok && WR_WORD) begin
                for (int l = 0; l < LANES; l++)
                    if (WR_BE[l]) m_mem[slot][l*8 +: 8] = DIN[l*8 +: 8];
                n_push++; m_bptr = 0; m_partial = 0;
            end else if (push_ok) begin
                m_mem[slot][m_bptr*8 +: 8] = DIN[m_bptr*8 +: 8];
                if (m_bptr == LANES - 1) begin
                    n_push++; m_bptr = 0; m_partial = 0;
                end else begin
                    m_bptr++; m_partial = 1;
                end
            end else if (BPTR_LD && !want_push && !m_partial) begin
                m_bptr = int'(BPTR_VAL);
            end
            m_ovf = set_ovf ? 1'b1 : (ERR_CLR ? 1'b0 : m_ovf);
            m_udf = set_udf ? 1'b1 : (ERR_CLR ? 1'b0 : m_udf);
        end
    end

    always @(negedge CLK) begin
        if (model_live) begin
            check("m_dout",      DOUT,              m_dout);
            check("m_dv",        32'(DOUT_VALID),   32'(m_dv));
            check("m_count",     32'(COUNT),        32'(n_push - n_pop));
            check("m_full",      32'(FULL),         32'((n_push - n_pop) == DEPTH));
            check("m_empty",     32'(EMPTY),        32'((n_push - n_pop) == 0));
            check("m_bptr",      32'(BPTR),         32'(m_bptr));
            check("m_bptr_eq0",  32'(BPTR_EQ0),     32'(m_bptr == 0));
            check("m_bptr_last", 32'(BPTR_LAST),    32'(m_bptr == LANES - 1));
            check("m_partial",   32'(PARTIAL),      32'(m_partial));
            check("m_ovf",       32'(OVF),          32'(m_ovf));
            check("m_udf",       32'(UDF),          32'(m_udf));
        end
    end

    task automatic idle();
        FLUSH = 0; DIN = '0; WR_WORD = 0; WR_BE = '0; WR_BYTE = 0;
        BPTR_LD = 0; BPTR_VAL = '0; RD = 0; ERR_CLR = 0;
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic drive(input logic ww, input logic [3:0] be, input logic wb,
                         input logic [31:0] din, input logic rd, input logic ld,
                         input logic [1:0] lv, input logic fl, input logic ec);
        WR_WORD = ww; WR_BE = be; WR_BYTE = wb; DIN = din; RD = rd;
        BPTR_LD = ld; BPTR_VAL = lv; FLUSH = fl; ERR_CLR = ec;
        @(posedge CLK); #1;
        idle();
    endtask

    task automatic push(input logic [31:0] d);
        drive(1, 4'hF, 0, d, 0, 0, 2'd0, 0, 0);
    endtask

    task automatic pop();
        drive(0, 4'h0, 0, 32'h0, 1, 0, 2'd0, 0, 0);
    endtask

    task automatic do_reset();
        RST_FIFO_ = 0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_FIFO_ = 1;
    endtask

    initial begin
        RST_FIFO_ = 0;
        idle();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full",  32'(FULL),  32'd0);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_beq0",  32'(BPTR_EQ0), 32'd1);
        check("rst_dout",  DOUT, 32'h0);
        RST_FIFO_ = 1;

        // Fill with eight words, then drain in order.
        push(32'h11111111);
        check("first_push_count", 32'(COUNT), 32'd1);
        for (int k = 2; k <= 8; k++) push(32'h11111111 * k);
        check("fill_full",  32'(FULL),  32'd1);
        check("fill_count", 32'(COUNT), 32'd8);
        for (int k = 1; k <= 8; k++) begin
            pop();
            check("drain_dv",   32'(DOUT_VALID), 32'd1);
            check("drain_dout", DOUT, 32'h11111111 * k);
        end
        check("drain_empty", 32'(EMPTY), 32'd1);
        check("drain_ovf",   32'(OVF),   32'd0);
        check("drain_udf",   32'(UDF),   32'd0);

        // Byte assembly from a loaded pointer.
        do_reset();
        drive(0, 4'h0, 0, 32'h0, 0, 1, 2'd2, 0, 0);
        check("ld_bptr", 32'(BPTR), 32'd2);
        drive(0, 4'h0, 1, 32'hAABBCCDD, 0, 0, 2'd0, 0, 0);
        check("b1_partial", 32'(PARTIAL), 32'd1);
        check("b1_count",   32'(COUNT),   32'd0);
        check("b1_bptr",    32'(BPTR),    32'd3);
        drive(0, 4'h0, 0, 32'h0, 0, 1, 2'd0, 0, 0);
        check("ld_ignored", 32'(BPTR), 32'd3);
        drive(0, 4'h0, 1, 32'hAABBCCDD, 0, 0, 2'd0, 0, 0);
        check("b2_count",   32'(COUNT),   32'd1);
        check("b2_bptr",    32'(BPTR),    32'd0);
        check("b2_partial", 32'(PARTIAL), 32'd0);
        pop();
        check("asm_dout", DOUT, 32'hAABB0000);

        // Word push with lane enables merges over an assembled byte; WR_BYTE ignored.
        drive(0, 4'h0, 1, 32'h000000EE, 0, 0, 2'd0, 0, 0);
        drive(1, 4'hE, 1, 32'h12345600, 0, 0, 2'd0, 0, 0);
        check("merge_count", 32'(COUNT), 32'd1);
        check("merge_bptr",  32'(BPTR),  32'd0);
        pop();
        check("merge_dout", DOUT, 32'h123456EE);

        // Overflow on full, then simultaneous push and pop.
        for (int k = 0; k < 8; k++) push(32'hC0DE0000 + k);
        push(32'hDEADBEEF);
        check("ovf_set",   32'(OVF),   32'd1);
        check("ovf_count", 32'(COUNT), 32'd8);
        drive(1, 4'hF, 0, 32'h55555555, 1, 0, 2'd0, 0, 0);
        check("pp_count", 32'(COUNT), 32'd8);
        check("pp_dout",  DOUT, 32'hC0DE0000);
        for (int k = 1; k < 8; k++) begin
            pop();
            check("pp_drain", DOUT, 32'hC0DE0000 + k);
        end
        pop();
        check("pp_last", DOUT, 32'h55555555);
        check("pp_empty", 32'(EMPTY), 32'd1);
        drive(0, 4'h0, 0, 32'h0, 0, 0, 2'd0, 0, 1);
        check("ovf_clr", 32'(OVF), 32'd0);

        // Underflow behaviour.
        pop();
        check("udf_set", 32'(UDF), 32'd1);
        check("udf_dv",  32'(DOUT_VALID), 32'd0);
        drive(0, 4'h0, 0, 32'h0, 0, 0, 2'd0, 0, 1);
        check("udf_clr", 32'(UDF), 32'd0);
        drive(1, 4'hF, 0, 32'h00000077, 1, 0, 2'd0, 0, 0);
        check("rw_empty_count", 32'(COUNT), 32'd1);
        check("rw_empty_udf",   32'(UDF),   32'd1);
        check("rw_empty_dv",    32'(DOUT_VALID), 32'd0);
        drive(0, 4'h0, 0, 32'h0, 1, 0, 2'd0, 0, 1);
        check("rd_clr_dout", DOUT, 32'h00000077);
        check("rd_clr_udf",  32'(UDF), 32'd0);
        drive(0, 4'h0, 0, 32'h0, 1, 0, 2'd0, 0, 1);
        check("set_wins_udf", 32'(UDF), 32'd1);

        // Reset between edges with data, a partial slot and a pending read.
        for (int k = 0; k < 5; k++) push(32'h50 + k);
        drive(0, 4'h0, 1, 32'h000000FF, 0, 0, 2'd0, 0, 0);
        check("pre_rst_count",   32'(COUNT),   32'd5);
        check("pre_rst_partial", 32'(PARTIAL), 32'd1);
        RD = 1;
        #2;
        RST_FIFO_ = 0;
        #1;
        check("arst_count",   32'(COUNT),   32'd0);
        check("arst_empty",   32'(EMPTY),   32'd1);
        check("arst_full",    32'(FULL),    32'd0);
        check("arst_partial", 32'(PARTIAL), 32'd0);
        check("arst_bptr",    32'(BPTR),    32'd0);
        check("arst_beq0",    32'(BPTR_EQ0), 32'd1);
        check("arst_udf",     32'(UDF),     32'd0);
        check("arst_dout",    DOUT,         32'h0);
        check("arst_dv",      32'(DOUT_VALID), 32'd0);
        RD = 0;
        @(posedge CLK); #1;
        check("arst_dv_hold", 32'(DOUT_VALID), 32'd0);
        RST_FIFO_ = 1;

        // Flush during a refill: pointers clear, DOUT holds, storage reusable.
        for (int k = 0; k < 3; k++) push(32'h60 + k);
        pop();
        check("refill_dout", DOUT, 32'h60);
        push(32'h63);
        push(32'h64);
        drive(1, 4'hF, 0, 32'hBAD0BAD0, 1, 0, 2'd0, 1, 0);
        check("flush_count", 32'(COUNT), 32'd0);
        check("flush_empty", 32'(EMPTY), 32'd1);
        check("flush_dout",  DOUT, 32'h60);
        check("flush_dv",    32'(DOUT_VALID), 32'd0);
        push(32'h99);
        pop();
        check("post_flush_dout", DOUT, 32'h99);

        @(posedge CLK); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DEPTH, default 8, number of words; SHALL be a power of two, at least 2.
REQ-002 Parameter LANES, default 4, byte lanes per word; word width W = 8*LANES; AW = clog2(DEPTH); BW = clog2(LANES).
REQ-003 CLK  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 RST_FIFO_  in  1  reset, asynchronous, active-low.
REQ-005 FLUSH  in  1  synchronous clear.
REQ-006 DIN  in  W  write data.
REQ-007 WR_WORD  in  1  word push; WR_BE  in  LANES  lane enables for WR_WORD.
REQ-008 WR_BYTE  in  1  byte write of lane BPTR of DIN into the slot being assembled.
REQ-009 BPTR_LD  in  1  load byte pointer; BPTR_VAL  in  BW  value to load.
REQ-010 RD  in  1  pop request.
REQ-011 ERR_CLR  in  1  clear sticky error flags.
REQ-012 DOUT  out  W  registered read data; DOUT_VALID  out  1  one-cycle pulse, DOUT updated.
REQ-013 FULL, EMPTY  out  1  each; COUNT  out  AW+1  committed words.
REQ-014 BPTR  out  BW  byte pointer; BPTR_EQ0, BPTR_LAST  out  1  each (BPTR==0, BPTR==LANES-1).
REQ-015 PARTIAL  out  1  uncommitted bytes present in the write slot; OVF, UDF  out  1  sticky overflow/underflow.

Function
REQ-016 Storage SHALL be DEPTH x W; write pointer WP and read pointer RP SHALL be AW bits and wrap modulo DEPTH.
REQ-017 Push acceptance SHALL require !FULL, or FULL with a pop accepted in the same cycle.
REQ-018 Accepted WR_WORD SHALL write lanes with WR_BE=1 into slot WP, keep any bytes already assembled in other lanes, increment WP, set BPTR to 0, clear PARTIAL.
REQ-019 Accepted WR_BYTE SHALL write DIN lane BPTR into the same lane of slot WP and increment BPTR modulo LANES.
REQ-020 WR_BYTE with BPTR==LANES-1 SHALL commit: WP increments, COUNT increments, PARTIAL clears.
REQ-021 Any other accepted WR_BYTE SHALL set PARTIAL; partial bytes SHALL NOT count in COUNT or be readable.
REQ-022 WR_WORD and WR_BYTE in the same cycle: WR_WORD SHALL take effect; WR_BYTE SHALL be ignored.
REQ-023 BPTR_LD SHALL load BPTR from BPTR_VAL without writing data, and SHALL be ignored while PARTIAL=1 or any write is active.
REQ-024 Accepted RD (!EMPTY) SHALL load DOUT with slot RP on the next edge, pulse DOUT_VALID for one cycle, increment RP; latency is 1 cycle.
REQ-025 DOUT SHALL hold its last value when no read is accepted.
REQ-026 Push and pop accepted in the same cycle SHALL leave COUNT unchanged.
REQ-027 COUNT SHALL be registered and range 0..DEPTH; FULL=(COUNT==DEPTH); EMPTY=(COUNT==0).
REQ-028 A rejected push (WR_WORD or WR_BYTE not accepted) SHALL set OVF; storage, WP and BPTR unchanged.
REQ-029 RD when EMPTY SHALL set UDF; a same-cycle push into an empty FIFO SHALL still be accepted, and the read SHALL be rejected.
REQ-030 ERR_CLR SHALL clear OVF/UDF; a set condition in the same cycle SHALL win.
REQ-031 FLUSH SHALL have priority over all inputs.
REQ-032 FLUSH SHALL zero WP, RP, COUNT, BPTR, PARTIAL, OVF, UDF and DOUT_VALID; FLUSH SHALL leave storage and DOUT unchanged.

Reset
REQ-033 RST_FIFO_ low SHALL immediately force: WP=RP=0, COUNT=0, EMPTY=1, FULL=0, BPTR=0, BPTR_EQ0=1, PARTIAL=0, OVF=UDF=0, DOUT=0, DOUT_VALID=0, all storage 0.
REQ-034 Reset asserted mid-assembly or mid-read SHALL discard partial bytes and the pending read, with no DOUT_VALID pulse.
REQ-035 After release, the first accepted operation SHALL occur on the first rising CLK edge with RST_FIFO_ high.

Verification (DEPTH=8, LANES=4)
REQ-036 8 WR_WORD (BE=F) of 0x11111111..0x88888888 then 8 RD -> FULL after 8th push; DOUT 0x11111111..0x88888888, each 1 cycle after RD; EMPTY at end; OVF=UDF=0.
REQ-037 Sequence:
  - BPTR_LD 2;
  - WR_BYTE DIN=0xAABBCCDD twice (BPTR 2 then 3);
  - RD.
  Required response:
  - after the first WR_BYTE: PARTIAL=1, COUNT=0;
  - after the second WR_BYTE: commit, COUNT=1, BPTR=0;
  - RD gives DOUT=0xAABB0000.
REQ-038 Full FIFO: WR_WORD alone -> OVF=1, COUNT=8; then WR_WORD+RD together -> COUNT stays 8, RP and WP both advance.
REQ-039 RD on empty -> UDF=1, DOUT_VALID=0; ERR_CLR -> UDF=0; RD+WR_WORD on empty -> COUNT=1, UDF=1.
REQ-040 COUNT=5, PARTIAL=1, then RST_FIFO_ low between edges -> all outputs at reset values immediately; then FLUSH on a repeat fill -> COUNT=0, DOUT held.
